// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS core:
// opcodes, functs, FSM states and ALU operation codes.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_JR  = 6'h08;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SLL = 4'b0011,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_op_e;

  function automatic logic [31:0] sext16(
    input logic [15:0] v
  );
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mips_alu32.sv
// Combinational 32-bit ALU: add, sub, and, or,
// nor, sll, signed slt, plus zero flag for beq.
module mips_alu32
  import mips_pkg::*;
(
  input  alu_op_e     op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [4:0]  shamt_i,
  output logic [31:0] y_o,
  output logic        zero_o
);

  logic lt;
  assign lt = $signed(a_i) < $signed(b_i);

  always_comb begin
    y_o = '0;
    unique case (op_i)
      ALU_AND: y_o = a_i & b_i;
      ALU_OR:  y_o = a_i | b_i;
      ALU_ADD: y_o = a_i + b_i;
      ALU_SUB: y_o = a_i - b_i;
      ALU_SLT: y_o = {31'b0, lt};
      ALU_NOR: y_o = ~(a_i | b_i);
      ALU_SLL: y_o = b_i << shamt_i;
      default: y_o = '0;
    endcase
  end

  assign zero_o = (y_o == '0);

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS subset core with a unified
// req/ready memory port, trapping and retire pulse.
module mips_multicycle_core
  import mips_pkg::*;
#(
  parameter int unsigned       ADDR_W           = 32,
  parameter logic [ADDR_W-1:0] RESET_PC         = '0,
  parameter bit                TRAP_ON_MISALIGN = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic              retire,
  output logic              trap,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_out
);

  typedef logic [ADDR_W-1:0] addr_t;

  state_e      state_q, state_d;
  addr_t       pc_q, pc_d;
  addr_t       pc4_q, pc4_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] mdr_q, mdr_d;
  logic        trap_q, trap_d;
  logic [31:0] rf_q [32];

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        req_c, we_c, ret_c;
  addr_t       addr_c;
  logic [31:0] wdata_c;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] tgt;
  logic [31:0] simm, zimm, rs_val, rt_val;

  assign op    = ir_q[31:26];
  assign rs    = ir_q[25:21];
  assign rt    = ir_q[20:16];
  assign rd    = ir_q[15:11];
  assign shamt = ir_q[10:6];
  assign funct = ir_q[5:0];
  assign imm   = ir_q[15:0];
  assign tgt   = ir_q[25:0];
  assign simm  = sext16(imm);
  assign zimm  = {16'b0, imm};

  assign rs_val = (rs == 5'd0) ? '0 : rf_q[rs];
  assign rt_val = (rt == 5'd0) ? '0 : rf_q[rt];

  logic is_r, i_addi, i_andi, i_lw, i_sw;
  logic i_beq, i_jal;
  logic f_add, f_and, f_nor, f_slt, f_sll, f_jr;
  logic legal;

  assign is_r   = (op == OP_RTYPE);
  assign i_addi = (op == OP_ADDI);
  assign i_andi = (op == OP_ANDI);
  assign i_lw   = (op == OP_LW);
  assign i_sw   = (op == OP_SW);
  assign i_beq  = (op == OP_BEQ);
  assign i_jal  = (op == OP_JAL);
  assign f_add  = is_r && (funct == F_ADD);
  assign f_and  = is_r && (funct == F_AND);
  assign f_nor  = is_r && (funct == F_NOR);
  assign f_slt  = is_r && (funct == F_SLT);
  assign f_sll  = is_r && (funct == F_SLL);
  assign f_jr   = is_r && (funct == F_JR);

  assign legal = f_add | f_and | f_nor | f_slt
               | f_sll | f_jr | i_addi | i_andi
               | i_lw | i_sw | i_beq | i_jal;

  alu_op_e     alu_op;
  logic [31:0] alu_b, alu_y;
  logic        alu_zero;

  always_comb begin
    alu_op = ALU_ADD;
    unique case (1'b1)
      f_and, i_andi: alu_op = ALU_AND;
      f_nor:         alu_op = ALU_NOR;
      f_slt:         alu_op = ALU_SLT;
      f_sll:         alu_op = ALU_SLL;
      i_beq:         alu_op = ALU_SUB;
      default:       alu_op = ALU_ADD;
    endcase
  end

  assign alu_b = (i_addi | i_lw | i_sw) ? simm
               : (i_andi ? zimm : b_q);

  mips_alu32 u_alu (
    .op_i    (alu_op),
    .a_i     (a_q),
    .b_i     (alu_b),
    .shamt_i (shamt),
    .y_o     (alu_y),
    .zero_o  (alu_zero)
  );

  logic [31:0] pc4_w;
  addr_t       br_pc, jal_pc, jr_pc, ea_addr;
  logic        mis_ls, mis_jr;

  assign pc4_w   = 32'(pc4_q);
  assign br_pc   = pc4_q + addr_t'({simm[29:0], 2'b00});
  assign jal_pc  = addr_t'({pc4_w[31:28], tgt, 2'b00});
  assign jr_pc   = addr_t'({a_q[31:2], 2'b00});
  assign ea_addr = addr_t'({alu_q[31:2], 2'b00});
  assign mis_ls  = TRAP_ON_MISALIGN && (alu_y[1:0] != 2'b00);
  assign mis_jr  = TRAP_ON_MISALIGN && (a_q[1:0] != 2'b00);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc4_d    = pc4_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    alu_d    = alu_q;
    mdr_d    = mdr_q;
    trap_d   = trap_q;
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    req_c    = 1'b0;
    we_c     = 1'b0;
    addr_c   = '0;
    wdata_c  = '0;
    ret_c    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        req_c  = 1'b1;
        addr_c = pc_q;
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc4_d   = pc_q + addr_t'(4);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d = rs_val;
        b_d = rt_val;
        if (!legal) begin
          trap_d  = 1'b1;
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_d   = alu_y;
        state_d = S_WB;
        if (i_lw || i_sw) begin
          if (mis_ls) begin
            trap_d  = 1'b1;
            state_d = S_HALT;
          end else begin
            state_d = S_MEM;
          end
        end else if (i_beq) begin
          pc_d    = alu_zero ? br_pc : pc4_q;
          ret_c   = 1'b1;
          state_d = S_FETCH;
        end else if (i_jal) begin
          rf_we    = 1'b1;
          rf_waddr = 5'd31;
          rf_wdata = pc4_w;
          pc_d     = jal_pc;
          ret_c    = 1'b1;
          state_d  = S_FETCH;
        end else if (f_jr) begin
          if (mis_jr) begin
            trap_d  = 1'b1;
            state_d = S_HALT;
          end else begin
            pc_d    = jr_pc;
            ret_c   = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_MEM: begin
        req_c   = 1'b1;
        we_c    = i_sw;
        addr_c  = ea_addr;
        wdata_c = i_sw ? b_q : '0;
        if (mem_ready) begin
          if (i_sw) begin
            pc_d    = pc4_q;
            ret_c   = 1'b1;
            state_d = S_FETCH;
          end else begin
            mdr_d   = mem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        rf_waddr = is_r ? rd : rt;
        rf_wdata = i_lw ? mdr_q : alu_q;
        pc_d     = pc4_q;
        ret_c    = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      pc4_q   <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      trap_q  <= trap_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (rf_we && rf_waddr != 5'd0) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  // reset_n gates the port so an in-flight request drops at once
  assign mem_req   = reset_n & req_c;
  assign mem_we    = reset_n & we_c;
  assign mem_addr  = reset_n ? addr_c : '0;
  assign mem_wdata = reset_n ? wdata_c : '0;
  assign retire    = ret_c;
  assign trap      = trap_q;
  assign halted    = (state_q == S_HALT);
  assign pc_out    = pc_q;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: vector
// table for ALU ops plus hand-written control sequences.
module tb_mips_multicycle_core;

  localparam logic [31:0] RPC = 32'h100;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_req, mem_we, mem_ready;
  logic        retire, trap, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;

  logic [31:0] img [256];
  logic [31:0] mem [256];
  int          wait_n = 0;
  int          wcnt = 0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_ret = 0;
  int ret_cyc [$];
  logic [31:0] rd_log [$];
  logic [31:0] wa_log [$];
  logic [31:0] wd_log [$];
  bit          chk_stable = 0;
  bit          pend = 0;
  logic [31:0] pend_addr = '0;

  mips_multicycle_core #(
    .ADDR_W           (32),
    .RESET_PC         (RPC),
    .TRAP_ON_MISALIGN (1'b1)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .retire    (retire),
    .trap      (trap),
    .halted    (halted),
    .pc_out    (pc_out)
  );

  always #5 clock = ~clock;

  assign mem_ready = mem_req && (wcnt >= wait_n);
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
      wcnt <= 0;
    end else begin
      if (mem_req && !mem_ready) wcnt <= wcnt + 1;
      else wcnt <= 0;
      if (mem_req && mem_we && mem_ready)
        mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  function automatic logic [31:0] ri(
    input logic [5:0] op, input logic [4:0] rs,
    input logic [4:0] rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  function automatic logic [31:0] rr(
    input logic [4:0] rs, input logic [4:0] rt,
    input logic [4:0] rd, input logic [4:0] sh,
    input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] rj(input logic [25:0] t);
    return {6'h03, t};
  endfunction

  function automatic logic [31:0] rg(input int i);
    return dut.rf_q[i[4:0]];
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h",
               nm, act, exp);
    end
  endtask

  task automatic clr_img();
    for (int i = 0; i < 256; i++) img[i] = '0;
  endtask

  task automatic put(input logic [31:0] a,
                     input logic [31:0] w);
    img[a[9:2]] = w;
  endtask

  task automatic sample();
    if (retire) begin
      n_ret++;
      ret_cyc.push_back(cyc);
    end
    if (mem_req && mem_ready) begin
      if (mem_we) begin
        wa_log.push_back(mem_addr);
        wd_log.push_back(mem_wdata);
      end else begin
        rd_log.push_back(mem_addr);
      end
    end
    if (chk_stable && pend) begin
      chk("req_hold", 32'(mem_req), 32'd1);
      chk("addr_hold", mem_addr, pend_addr);
    end
    pend = mem_req && !mem_ready;
    pend_addr = mem_addr;
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
    cyc++;
    sample();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic start();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_retire", 32'(retire), 32'd0);
    chk("rst_trap", 32'(trap), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_pc_out", pc_out, RPC);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    cyc = 1;
    n_ret = 0;
    ret_cyc.delete();
    rd_log.delete();
    wa_log.delete();
    wd_log.delete();
    pend = 0;
    sample();
  endtask

  typedef struct {
    logic [31:0] ins;
    int          rd;
    logic [31:0] exp;
  } vec_t;

  vec_t tv [11];

  logic [31:0] park;
  logic [31:0] fexp [8];

  task automatic trap_case(input string nm,
                           input logic [31:0] w1,
                           input int ra, input logic [31:0] ea,
                           input int rb, input logic [31:0] eb);
    clr_img();
    wait_n = 0;
    put(RPC, (ra == 1) ? ri(6'h08, 5'd0, 5'd1, 16'd7)
                       : ri(6'h08, 5'd0, 5'd2, 16'd6));
    put(RPC + 4, w1);
    put(RPC + 8, park);
    start();
    run(11);
    chk({nm, "_trap"}, 32'(trap), 32'd1);
    chk({nm, "_halted"}, 32'(halted), 32'd1);
    chk({nm, "_req"}, 32'(mem_req), 32'd0);
    chk({nm, "_ret"}, 32'(n_ret), 32'd1);
    chk({nm, "_reads"}, 32'(rd_log.size()), 32'd2);
    chk({nm, "_ra"}, rg(ra), ea);
    chk({nm, "_rb"}, rg(rb), eb);
    run(4);
    chk({nm, "_req_late"}, 32'(mem_req), 32'd0);
    chk({nm, "_ret_late"}, 32'(n_ret), 32'd1);
    chk({nm, "_trap_late"}, 32'(trap), 32'd1);
  endtask

  initial begin
    logic [31:0] acc;
    bit          found;
    park = ri(6'h04, 5'd0, 5'd0, 16'hFFFF);

    tv[0]  = '{ri(6'h08, 0, 1, 16'hFFFF), 1, 32'hFFFF_FFFF};
    tv[1]  = '{ri(6'h08, 0, 2, 16'h0001), 2, 32'h0000_0001};
    tv[2]  = '{rr(1, 2, 3, 0, 6'h2A), 3, 32'h0000_0001};
    tv[3]  = '{rr(0, 0, 4, 0, 6'h27), 4, 32'hFFFF_FFFF};
    tv[4]  = '{rr(0, 2, 5, 4, 6'h00), 5, 32'h0000_0010};
    tv[5]  = '{rr(1, 2, 6, 0, 6'h24), 6, 32'h0000_0001};
    tv[6]  = '{ri(6'h0C, 1, 7, 16'h8000), 7, 32'h0000_8000};
    tv[7]  = '{rr(1, 1, 8, 0, 6'h20), 8, 32'hFFFF_FFFE};
    tv[8]  = '{rr(2, 1, 9, 0, 6'h2A), 9, 32'h0000_0000};
    tv[9]  = '{ri(6'h08, 2, 10, 16'hFFFD), 10, 32'hFFFF_FFFE};
    tv[10] = '{ri(6'h08, 0, 0, 16'h0005), 0, 32'h0000_0000};

    // first instruction from RESET_PC, zero-wait
    clr_img();
    put(RPC, ri(6'h08, 5'd0, 5'd1, 16'd5));
    put(RPC + 4, park);
    start();
    chk("t1_req", 32'(mem_req), 32'd1);
    chk("t1_we", 32'(mem_we), 32'd0);
    chk("t1_addr", mem_addr, RPC);
    chk("t1_pc_out", pc_out, RPC);
    run(3);
    chk("t1_retire_c4", 32'(retire), 32'd1);
    chk("t1_nret", 32'(n_ret), 32'd1);
    tick();
    chk("t1_r1", rg(1), 32'd5);
    chk("t1_next_addr", mem_addr, RPC + 4);
    chk("t1_pc_out2", pc_out, RPC + 4);

    // ALU vectors, one per 4-cycle instruction
    clr_img();
    for (int k = 0; k < 11; k++) put(RPC + 32'(4 * k), tv[k].ins);
    put(RPC + 44, park);
    start();
    run(43);
    chk("t2_nret", 32'(n_ret), 32'd11);
    for (int k = 0; k < 11; k++) begin
      chk($sformatf("t2_ret_cyc%0d", k),
          32'(ret_cyc[k]), 32'(4 * (k + 1)));
      chk($sformatf("t2_r%0d", tv[k].rd), rg(tv[k].rd), tv[k].exp);
    end

    // sw then lw with 3 wait cycles on every access
    clr_img();
    wait_n = 3;
    put(RPC, ri(6'h08, 5'd0, 5'd1, 16'hFFFF));
    put(RPC + 4, ri(6'h2B, 5'd0, 5'd1, 16'd8));
    put(RPC + 8, ri(6'h23, 5'd0, 5'd6, 16'd8));
    put(RPC + 12, park);
    put(32'd8, 32'h1234_5678);
    chk_stable = 1;
    start();
    run(30);
    chk_stable = 0;
    chk("t3_ret0", 32'(ret_cyc[0]), 32'd7);
    chk("t3_ret_sw", 32'(ret_cyc[1]), 32'd17);
    chk("t3_ret_lw", 32'(ret_cyc[2]), 32'd28);
    chk("t3_nwr", 32'(wa_log.size()), 32'd1);
    chk("t3_waddr", wa_log[0], 32'd8);
    chk("t3_wdata", wd_log[0], 32'hFFFF_FFFF);
    chk("t3_raddr", rd_log[3], 32'd8);
    chk("t3_r6", rg(6), 32'hFFFF_FFFF);

    // control flow: beq back, jal, jr, beq self-loop
    clr_img();
    wait_n = 0;
    put(RPC, ri(6'h04, 5'd31, 5'd0, 16'hFFBF));
    put(32'h0, rj(26'h40));
    put(RPC + 4, rr(5'd31, 5'd0, 5'd0, 5'd0, 6'h08));
    put(32'h4, rj(26'h8));
    put(32'h20, park);
    fexp = '{32'h100, 32'h0, 32'h100, 32'h104,
             32'h4, 32'h20, 32'h20, 32'h20};
    start();
    run(22);
    chk("t4_nfetch", 32'(rd_log.size()), 32'd8);
    for (int k = 0; k < 8; k++)
      chk($sformatf("t4_fetch%0d", k), rd_log[k], fexp[k]);
    chk("t4_ret0", 32'(ret_cyc[0]), 32'd3);
    chk("t4_ret4", 32'(ret_cyc[4]), 32'd15);
    chk("t4_r31", rg(31), 32'h8);

    // traps: illegal opcode, misaligned lw, illegal funct
    trap_case("t5_op", 32'hFC00_0000, 1, 32'd7, 2, 32'd0);
    trap_case("t5_mis", ri(6'h23, 5'd2, 5'd3, 16'd0),
              2, 32'd6, 3, 32'd0);
    trap_case("t5_fn", rr(5'd0, 5'd0, 5'd1, 5'd0, 6'h3F),
              1, 32'd7, 0, 32'd0);

    // reset while a store waits for ready
    clr_img();
    wait_n = 3;
    put(RPC, ri(6'h08, 5'd0, 5'd1, 16'hFFFF));
    put(RPC + 4, ri(6'h2B, 5'd0, 5'd1, 16'd8));
    put(RPC + 8, park);
    start();
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (mem_req && mem_we) found = 1;
    end
    chk("t6_sw_seen", 32'(found), 32'd1);
    chk("t6_no_write", 32'(wa_log.size()), 32'd0);
    chk("t6_r1_pre", rg(1), 32'hFFFF_FFFF);
    #1;
    reset_n = 1'b0;
    #1;
    chk("t6_req_drop", 32'(mem_req), 32'd0);
    chk("t6_we_drop", 32'(mem_we), 32'd0);
    start();
    chk("t6_addr", mem_addr, RPC);
    chk("t6_pc_out", pc_out, RPC);
    acc = '0;
    for (int i = 1; i < 32; i++) acc = acc | rg(i);
    chk("t6_regs_zero", acc, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
